// File: rtl/lab022_axil_pkg.sv
// Shared types and constants for the lab022 AXI4-Lite register file.
package lab022_axil_pkg;

    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] cur_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = cur_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = cur_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lab022_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers exported as reg_out.
// Write and read channels run as independent FSMs over one register array.
module lab022_axil_regs
    import lab022_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                     s00_axi_awprot,
    input  logic                           s00_axi_awvalid,
    output logic                           s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                           s00_axi_wvalid,
    output logic                           s00_axi_wready,
    output logic [1:0]                     s00_axi_bresp,
    output logic                           s00_axi_bvalid,
    input  logic                           s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                     s00_axi_arprot,
    input  logic                           s00_axi_arvalid,
    output logic                           s00_axi_arready,
    output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                     s00_axi_rresp,
    output logic                           s00_axi_rvalid,
    input  logic                           s00_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    wr_state_t                 wr_state_q, wr_state_d;
    logic                      aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic                      w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    resp_t                     bresp_q, bresp_d;

    rd_state_t                 rd_state_q, rd_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    resp_t                     rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];

    logic                      aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_WIDTH-1:0]     aw_addr_s;
    logic [DATA_WIDTH-1:0]     w_data_s;
    logic [DATA_WIDTH/8-1:0]   w_strb_s;
    logic                      w_mapped_s, r_mapped_s;
    logic [REG_IDX_W-1:0]      w_idx_s, r_idx_s;
    logic                      unused_ok;

    assign aw_hs_s = s00_axi_awvalid & awready_q;
    assign w_hs_s  = s00_axi_wvalid & wready_q;
    assign ar_hs_s = s00_axi_arvalid & arready_q;

    // Effective write address/data: the latched copy if held, otherwise the live bus.
    always_comb begin
        if (aw_held_q) begin
            aw_addr_s = awaddr_q;
        end else begin
            aw_addr_s = s00_axi_awaddr;
        end
        if (w_held_q) begin
            w_data_s = wdata_q;
            w_strb_s = wstrb_q;
        end else begin
            w_data_s = s00_axi_wdata;
            w_strb_s = s00_axi_wstrb;
        end
    end

    assign w_idx_s    = aw_addr_s[3:2];
    assign w_mapped_s = ~|aw_addr_s[ADDR_WIDTH-1:4];
    assign r_idx_s    = s00_axi_araddr[3:2];
    assign r_mapped_s = ~|s00_axi_araddr[ADDR_WIDTH-1:4];
    assign unused_ok  = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_s[1:0], s00_axi_araddr[1:0]};

    // Write FSM: collect AW and W in any order, commit once both are present.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        commit_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s00_axi_awaddr;
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_hs_s) begin
                    w_held_d = 1'b1;
                    wdata_d  = s00_axi_wdata;
                    wstrb_d  = s00_axi_wstrb;
                end else begin
                    w_held_d = w_held_q;
                end
                if ((aw_held_q | aw_hs_s) & (w_held_q | w_hs_s)) begin
                    commit_s   = 1'b1;
                    wr_state_d = W_RESP;
                    bvalid_d   = 1'b1;
                    if (w_mapped_s) begin
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awaddr_d   = {ADDR_WIDTH{1'b0}};
                    wdata_d    = {DATA_WIDTH{1'b0}};
                    wstrb_d    = {(DATA_WIDTH/8){1'b0}};
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                bvalid_d   = 1'b0;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
            end
        endcase
        awready_d = (wr_state_d == W_IDLE) & ~aw_held_d;
        wready_d  = (wr_state_d == W_IDLE) & ~w_held_d;
    end

    // Register array next state: byte-strobed update on a mapped commit.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit_s & w_mapped_s) begin
            regs_d[w_idx_s] = strb_merge(regs_q[w_idx_s], w_data_s, w_strb_s);
        end else begin
            regs_d[w_idx_s] = regs_q[w_idx_s];
        end
    end

    // Read FSM: rdata sampled from regs_q, so a same-edge write is not visible yet.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    if (r_mapped_s) begin
                        rresp_d = RESP_OKAY;
                        rdata_d = regs_q[r_idx_s];
                    end else begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rvalid_d   = 1'b0;
            end
        endcase
        arready_d = (rd_state_d == R_IDLE);
    end

    // Write channel state and response registers.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            awaddr_q   <= {ADDR_WIDTH{1'b0}};
            w_held_q   <= 1'b0;
            wdata_q    <= {DATA_WIDTH{1'b0}};
            wstrb_q    <= {(DATA_WIDTH/8){1'b0}};
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read channel state and response registers.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    // Register array storage.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flatten the array onto reg_out, reg0 in the low word.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_lab022_axil_regs.sv
// Directed scoreboard bench for lab022_axil_regs: expected B/R responses are queued
// when a transaction is driven and compared when the DUT responds.
module tb_lab022_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk;
    logic         areset;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_out;

    int checks;
    int failures;
    logic [31:0] m_regs [4];
    logic [33:0] sb_b [$];
    logic [33:0] sb_r [$];

    lab022_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg_out         (reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    function automatic logic [127:0] model_out();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    // Independent byte-lane model of a strobed register write.
    task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] v;
        if (addr[5:4] == 2'b00) begin
            v = m_regs[addr[3:2]];
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
            end
            m_regs[addr[3:2]] = v;
            sb_b.push_back({OKAY, 32'h0});
        end else begin
            sb_b.push_back({SLVERR, 32'h0});
        end
    endtask

    task automatic model_read(input logic [5:0] addr);
        if (addr[5:4] == 2'b00) sb_r.push_back({OKAY, m_regs[addr[3:2]]});
        else sb_r.push_back({SLVERR, 32'h0});
    endtask

    task automatic pop_b(input string tag);
        logic [33:0] e;
        if (sb_b.size() == 0) begin
            timeout_fail({tag, "_sb_empty"});
        end else begin
            e = sb_b.pop_front();
            check(tag, {bresp, 32'h0}, e);
        end
    endtask

    task automatic pop_r(input string tag);
        logic [33:0] e;
        if (sb_r.size() == 0) begin
            timeout_fail({tag, "_sb_empty"});
        end else begin
            e = sb_r.pop_front();
            check(tag, {rresp, rdata}, e);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string tag);
        bit aw_done, w_done, aw_go, w_go;
        int n;
        model_write(addr, data, strb);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick;
            if (aw_go) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_go)  begin w_done = 1'b1; wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout_fail({tag, "_aw_w"});
        check({tag, "_bvalid_lat"}, bvalid, 1'b1);
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        if (!bvalid) timeout_fail({tag, "_b"});
        pop_b({tag, "_bresp"});
        check({tag, "_reg_out"}, reg_out, model_out());
        bready = 1'b1;
        tick;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr, input string tag);
        int n;
        model_read(addr);
        araddr = addr; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin tick; n++; end
        if (!arready) timeout_fail({tag, "_ar"});
        tick;
        arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, rvalid, 1'b1);
        pop_r({tag, "_rdata"});
        rready = 1'b1;
        tick;
        rready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        areset = 1'b1;
        awaddr = 6'h0; awprot = 3'h0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 6'h0; arprot = 3'h0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) tick;
        areset = 1'b0;
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resps", {bresp, rresp}, 4'h0);
        check("rst_reg_out", reg_out, 128'h0);

        // Sequential writes and read-back
        do_write(6'h00, 32'h1, 4'hF, "seq_w0");
        do_write(6'h04, 32'h2, 4'hF, "seq_w1");
        do_write(6'h08, 32'h3, 4'hF, "seq_w2");
        do_write(6'h0C, 32'h4, 4'hF, "seq_w3");
        do_read(6'h00, "seq_r0");
        do_read(6'h04, "seq_r1");
        do_read(6'h08, "seq_r2");
        do_read(6'h0C, "seq_r3");
        check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

        // AW well ahead of W
        model_write(6'h04, 32'hDEADBEEF, 4'hF);
        awaddr = 6'h04; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        check("ord_awready_low", awready, 1'b0);
        check("ord_wready_high", wready, 1'b1);
        tick;
        tick;
        check("ord_no_bvalid", bvalid, 1'b0);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        check("ord_bvalid_lat", bvalid, 1'b1);
        pop_b("ord_bresp");
        check("ord_reg_out", reg_out, model_out());
        bready = 1'b1; tick; bready = 1'b0;
        do_read(6'h04, "ord_r1");

        // Partial strobe
        do_write(6'h00, 32'h11223344, 4'hF, "strb_init");
        do_write(6'h00, 32'hAABBCCDD, 4'b0101, "strb_part");
        check("strb_reg0", reg_out[31:0], 32'h11BB33DD);
        do_read(6'h00, "strb_r0");

        // B backpressure with a second AW waiting
        model_write(6'h08, 32'h0BADF00D, 4'hF);
        awaddr = 6'h08; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        awaddr = 6'h0C;
        check("bp_bvalid_lat", bvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_b_hold", {bvalid, bresp, awready, wready}, {1'b1, OKAY, 1'b0, 1'b0});
            tick;
        end
        pop_b("bp_bresp");
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("bp_bvalid_clear", bvalid, 1'b0);
        check("bp_awready_back", {awready, wready}, 2'b11);
        model_write(6'h0C, 32'h600DCAFE, 4'hF);
        wdata = 32'h600DCAFE; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_second_bvalid", bvalid, 1'b1);
        pop_b("bp_second_bresp");
        check("bp_second_reg_out", reg_out, model_out());
        bready = 1'b1; tick; bready = 1'b0;

        // R backpressure
        model_read(6'h08);
        araddr = 6'h08; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_r_hold", {rvalid, rresp, rdata, arready}, {1'b1, OKAY, 32'h0BADF00D, 1'b0});
            tick;
        end
        pop_r("bp_rdata");
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("bp_r_release", {rvalid, arready}, 2'b01);

        // Unmapped addresses
        do_write(6'h10, 32'h55, 4'hF, "unm_w10");
        do_read(6'h20, "unm_r20");

        // Same-edge read and write of one register returns the old value
        model_read(6'h0C);
        model_write(6'h0C, 32'h77777777, 4'hF);
        awaddr = 6'h0C; wdata = 32'h77777777; wstrb = 4'hF; araddr = 6'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("col_valids", {bvalid, rvalid}, 2'b11);
        pop_r("col_rdata_old");
        pop_b("col_bresp");
        check("col_reg_out", reg_out, model_out());
        bready = 1'b1; rready = 1'b1; tick; bready = 1'b0; rready = 1'b0;

        // Reset while both responses are pending
        model_write(6'h00, 32'hCAFEF00D, 4'hF);
        void'(sb_b.pop_back());
        awaddr = 6'h00; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mr_pending", {bvalid, rvalid}, 2'b11);
        check("mr_pre_reg_out", reg_out, model_out());
        tick;
        areset = 1'b1;
        tick;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        check("mr_valids_clear", {bvalid, rvalid}, 2'b00);
        check("mr_reg_out_zero", reg_out, 128'h0);
        check("mr_readies", {awready, wready, arready}, 3'b111);
        do_write(6'h04, 32'h12345678, 4'hF, "mr_w1");
        do_read(6'h04, "mr_r1");
        check("mr_sb_drained", sb_b.size() + sb_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
